// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer for a 5-stage pipe: load-use stalls, multi-cycle data-memory
// holds and IF/ID flushes on taken branches, plus a saturating stall-cycle counter.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int LU_STALL_CYC = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             IDEX_MemRd_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_bubble_o,
  output logic             exmem_stall_o,
  output logic             memwb_bubble_o,
  output logic             timeout_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam int LU_W = $clog2(LU_STALL_CYC + 1);
  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [LU_W-1:0]  LU_ONE   = LU_W'(1'b1);
  localparam logic [LU_W-1:0]  LU_START = LU_W'(LU_STALL_CYC - 1);
  localparam logic [WT_W-1:0]  WT_ONE   = WT_W'(1'b1);
  localparam logic [WT_W-1:0]  WT_LIMIT = WT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Strobe vector order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_bubble
  localparam logic [6:0] STRB_NONE   = 7'b0000000;
  localparam logic [6:0] STRB_FREEZE = 7'b1101011;
  localparam logic [6:0] STRB_LU     = 7'b1100100;
  localparam logic [6:0] STRB_FLUSH  = 7'b0010000;

  state_t            state_r;
  state_t            ret_r;
  logic [LU_W-1:0]   lu_cnt_r;
  logic [WT_W-1:0]   wait_cnt_r;
  logic              timeout_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  state_t            state_nx_s;
  state_t            ret_nx_s;
  logic [LU_W-1:0]   lu_cnt_nx_s;
  logic [WT_W-1:0]   wait_cnt_nx_s;
  logic              tout_set_s;
  logic [6:0]        strb_s;
  logic              lu_haz_s;
  logic              mem_busy_s;

  assign lu_haz_s   = IDEX_MemRd_i && (IDEX_rt_i != 5'd0) &&
                      ((IDEX_rt_i == IFID_rs_i) || (IDEX_rt_i == IFID_rt_i));
  // A request that drops without an ack is treated exactly like an ack.
  assign mem_busy_s = dmem_req_i && !dmem_ack_i;

  // Next-state and Mealy strobe selection from registered state and live hazard inputs.
  always_comb begin
    state_nx_s    = state_r;
    ret_nx_s      = ret_r;
    lu_cnt_nx_s   = lu_cnt_r;
    wait_cnt_nx_s = wait_cnt_r;
    tout_set_s    = 1'b0;
    strb_s        = STRB_NONE;
    case (state_r)
      ST_RUN: begin
        if (mem_busy_s) begin
          strb_s        = STRB_FREEZE;
          ret_nx_s      = ST_RUN;
          wait_cnt_nx_s = WT_ONE;
          state_nx_s    = ST_MEM_WAIT;
        end else if (lu_haz_s) begin
          strb_s = STRB_LU;
          if (LU_STALL_CYC > 1) begin
            lu_cnt_nx_s = LU_START;
            state_nx_s  = ST_LU_STALL;
          end else begin
            state_nx_s  = ST_RUN;
          end
        end else if (branch_taken_i) begin
          strb_s = STRB_FLUSH;
        end else begin
          strb_s = STRB_NONE;
        end
      end
      ST_LU_STALL: begin
        if (mem_busy_s) begin
          strb_s        = STRB_FREEZE;
          ret_nx_s      = ST_LU_STALL;
          wait_cnt_nx_s = WT_ONE;
          state_nx_s    = ST_MEM_WAIT;
        end else begin
          // Branch is ignored here; the held ID instruction presents it again afterwards.
          strb_s      = STRB_LU;
          lu_cnt_nx_s = lu_cnt_r - LU_ONE;
          if (lu_cnt_r == LU_ONE) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_LU_STALL;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_busy_s) begin
          strb_s     = STRB_NONE;
          state_nx_s = ret_r;
        end else if (wait_cnt_r == WT_LIMIT) begin
          strb_s     = STRB_NONE;
          tout_set_s = 1'b1;
          state_nx_s = ret_r;
        end else begin
          strb_s        = STRB_FREEZE;
          wait_cnt_nx_s = wait_cnt_r + WT_ONE;
        end
      end
      default: begin
        strb_s     = STRB_NONE;
        state_nx_s = ST_RUN;
      end
    endcase
  end

  // State, counters, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_RUN;
      ret_r       <= ST_RUN;
      lu_cnt_r    <= {LU_W{1'b0}};
      wait_cnt_r  <= {WT_W{1'b0}};
      timeout_r   <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      ret_r      <= ret_nx_s;
      lu_cnt_r   <= lu_cnt_nx_s;
      wait_cnt_r <= wait_cnt_nx_s;
      if (tout_set_s) begin
        timeout_r <= 1'b1;
      end
      if (strb_s[6] && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
    end
  end

  // Strobes are forced low while reset is asserted regardless of the inputs.
  assign pc_stall_o     = rst_n_i && strb_s[6];
  assign ifid_stall_o   = rst_n_i && strb_s[5];
  assign ifid_flush_o   = rst_n_i && strb_s[4];
  assign idex_stall_o   = rst_n_i && strb_s[3];
  assign idex_bubble_o  = rst_n_i && strb_s[2];
  assign exmem_stall_o  = rst_n_i && strb_s[1];
  assign memwb_bubble_o = rst_n_i && strb_s[0];

  assign timeout_o      = timeout_r;
  assign state_o        = state_r;
  assign stall_cycles_o = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: dut_a (LU_STALL_CYC=3, MEM_TIMEOUT=8) and
// dut_b (LU_STALL_CYC=1, defaults) share stimulus; each cycle's expectation names its DUT.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_FRZ  = 7'b1101011;
  localparam logic [6:0] S_LU   = 7'b1100100;
  localparam logic [6:0] S_FL   = 7'b0010000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idex_memrd = 1'b1;
  logic [4:0] idex_rt = 5'd8;
  logic [4:0] ifid_rs = 5'd8;
  logic [4:0] ifid_rt = 5'd1;
  logic branch_taken = 1'b1;
  logic dmem_req = 1'b1;
  logic dmem_ack = 1'b0;

  logic pc_stall_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_bubble_a, exmem_stall_a, memwb_bubble_a;
  logic pc_stall_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_bubble_b, exmem_stall_b, memwb_bubble_b;
  logic timeout_a, timeout_b;
  logic [1:0] state_a, state_b;
  logic [31:0] cnt_a, cnt_b;
  logic [6:0] strb_a, strb_b;

  assign strb_a = {pc_stall_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_bubble_a, exmem_stall_a, memwb_bubble_a};
  assign strb_b = {pc_stall_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_bubble_b, exmem_stall_b, memwb_bubble_b};

  pipe_hazard_ctrl #(.LU_STALL_CYC(3), .MEM_TIMEOUT(8), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .IDEX_MemRd_i(idex_memrd), .IDEX_rt_i(idex_rt),
    .IFID_rs_i(ifid_rs), .IFID_rt_i(ifid_rt), .branch_taken_i(branch_taken),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .pc_stall_o(pc_stall_a), .ifid_stall_o(ifid_stall_a), .ifid_flush_o(ifid_flush_a),
    .idex_stall_o(idex_stall_a), .idex_bubble_o(idex_bubble_a), .exmem_stall_o(exmem_stall_a),
    .memwb_bubble_o(memwb_bubble_a), .timeout_o(timeout_a), .state_o(state_a), .stall_cycles_o(cnt_a)
  );

  pipe_hazard_ctrl #(.LU_STALL_CYC(1), .MEM_TIMEOUT(64), .CNT_W(32)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .IDEX_MemRd_i(idex_memrd), .IDEX_rt_i(idex_rt),
    .IFID_rs_i(ifid_rs), .IFID_rt_i(ifid_rt), .branch_taken_i(branch_taken),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .pc_stall_o(pc_stall_b), .ifid_stall_o(ifid_stall_b), .ifid_flush_o(ifid_flush_b),
    .idex_stall_o(idex_stall_b), .idex_bubble_o(idex_bubble_b), .exmem_stall_o(exmem_stall_b),
    .memwb_bubble_o(memwb_bubble_b), .timeout_o(timeout_b), .state_o(state_b), .stall_cycles_o(cnt_b)
  );

  // 10 ns clock; inputs change on the falling edge, outputs sampled 2 ns later.
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          dut;
    logic [6:0]  strb;
    logic [1:0]  st;
    logic        tout;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input int dut,
                      input logic memrd, input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                      input logic br, input logic req, input logic ack,
                      input logic [6:0] strb, input logic [1:0] st, input logic tout);
    exp_t e;
    @(negedge clk);
    idex_memrd = memrd; idex_rt = ert; ifid_rs = rs; ifid_rt = rt;
    branch_taken = br; dmem_req = req; dmem_ack = ack;
    e.tag = tag; e.dut = dut; e.strb = strb; e.st = st; e.tout = tout;
    e.cnt = (dut == 0) ? exp_cnt_a : exp_cnt_b;
    sb_q.push_back(e);
    if (strb[6]) begin
      if (dut == 0) exp_cnt_a++;
      else exp_cnt_b++;
    end
    #2;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (e.dut == 0) begin
        check_eq({e.tag, "_strb"}, {25'd0, strb_a}, {25'd0, e.strb});
        check_eq({e.tag, "_state"}, {30'd0, state_a}, {30'd0, e.st});
        check_eq({e.tag, "_tout"}, {31'd0, timeout_a}, {31'd0, e.tout});
        check_eq({e.tag, "_cnt"}, cnt_a, e.cnt);
      end else begin
        check_eq({e.tag, "_strb"}, {25'd0, strb_b}, {25'd0, e.strb});
        check_eq({e.tag, "_state"}, {30'd0, state_b}, {30'd0, e.st});
        check_eq({e.tag, "_tout"}, {31'd0, timeout_b}, {31'd0, e.tout});
        check_eq({e.tag, "_cnt"}, cnt_b, e.cnt);
      end
    end
  endtask

  // Asserts reset with the current inputs left in place, checks both DUTs, then releases.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_eq({tag, "_strb_a"}, {25'd0, strb_a}, 32'd0);
    check_eq({tag, "_strb_b"}, {25'd0, strb_b}, 32'd0);
    check_eq({tag, "_state_a"}, {30'd0, state_a}, 32'd0);
    check_eq({tag, "_tout_a"}, {31'd0, timeout_a}, 32'd0);
    check_eq({tag, "_cnt_a"}, cnt_a, 32'd0);
    check_eq({tag, "_cnt_b"}, cnt_b, 32'd0);
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    @(negedge clk);
    idex_memrd = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with hazard, branch and memory request all active.
    do_reset("rst0");

    // T1: single-cycle load-use stall (dut_b).
    step("t1_lu",   1, 1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, S_LU,   2'd0, 1'b0);
    step("t1_idle", 1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_NONE, 2'd0, 1'b0);
    do_reset("rst1");

    // T2: three-cycle load-use stall, hazard on rt.
    step("t2_c0", 0, 1'b1, 5'd8, 5'd1, 5'd8, 1'b0, 1'b0, 1'b0, S_LU,   2'd0, 1'b0);
    step("t2_c1", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_LU,   2'd1, 1'b0);
    step("t2_c2", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_LU,   2'd1, 1'b0);
    step("t2_c3", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_NONE, 2'd0, 1'b0);

    // T3: $0 never hazards; branch flush; load-use outranks branch, branch re-seen afterwards.
    step("t3_r0",   0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, S_NONE, 2'd0, 1'b0);
    step("t3_br",   0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, S_FL,   2'd0, 1'b0);
    step("t3_idle", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_NONE, 2'd0, 1'b0);
    step("t3_hb0",  0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0, S_LU,   2'd0, 1'b0);
    step("t3_hb1",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, S_LU,   2'd1, 1'b0);
    step("t3_hb2",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, S_LU,   2'd1, 1'b0);
    step("t3_hb3",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, S_FL,   2'd0, 1'b0);
    step("t3_end",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_NONE, 2'd0, 1'b0);

    // T4: memory ack after 4 freeze cycles; then a request dropped without ack.
    step("t4_f0",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_FRZ,  2'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("t4_fw", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_FRZ,  2'd2, 1'b0);
    step("t4_ack", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, S_NONE, 2'd2, 1'b0);
    step("t4_run", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_NONE, 2'd0, 1'b0);
    step("t4_d0",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_FRZ,  2'd0, 1'b0);
    step("t4_drop",0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_NONE, 2'd2, 1'b0);
    step("t4_d2",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_NONE, 2'd0, 1'b0);

    // T5: no ack, MEM_TIMEOUT=8: release on the 8th wait cycle, sticky timeout.
    step("t5_f0",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_FRZ,  2'd0, 1'b0);
    for (int i = 0; i < 7; i++)
      step("t5_fw", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_FRZ,  2'd2, 1'b0);
    step("t5_rel", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_NONE, 2'd2, 1'b0);
    step("t5_st0", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_NONE, 2'd0, 1'b1);
    step("t5_st1", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_NONE, 2'd0, 1'b1);

    // T6: memory wait interleaved into a load-use stall; lu count resumes where it left off.
    step("t6_lu0", 0, 1'b1, 5'd9, 5'd9, 5'd3, 1'b0, 1'b0, 1'b0, S_LU,   2'd0, 1'b1);
    step("t6_m0",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_FRZ,  2'd1, 1'b1);
    step("t6_m1",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_FRZ,  2'd2, 1'b1);
    step("t6_ack", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, S_NONE, 2'd2, 1'b1);
    step("t6_lu1", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_LU,   2'd1, 1'b1);
    step("t6_lu2", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_LU,   2'd1, 1'b1);
    step("t6_run", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_NONE, 2'd0, 1'b1);
    step("t6_w0",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_FRZ,  2'd0, 1'b1);
    step("t6_w1",  0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_FRZ,  2'd2, 1'b1);
    do_reset("rst_mid");
    step("t6_post", 0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, S_NONE, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
